// File: rtl/ps2_morse_pkg.sv
// Shared types, scan-code constants and helper functions for the PS/2 Morse decoder.
package ps2_morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        LGAP = 2'd3
    } seq_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] SPACE_CODE = 8'h29;

    // pat is left-aligned: first element in pat[4], 1 = dash; len 0 marks the word gap
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_entry_t;

    function automatic morse_entry_t morse_lookup(input logic [7:0] code);
        morse_entry_t e;
        case (code)
            8'h1C:      e = {1'b1, 3'd2, 5'b01000}; // A
            8'h32:      e = {1'b1, 3'd4, 5'b10000}; // B
            8'h21:      e = {1'b1, 3'd4, 5'b10100}; // C
            8'h23:      e = {1'b1, 3'd3, 5'b10000}; // D
            8'h24:      e = {1'b1, 3'd1, 5'b00000}; // E
            8'h2B:      e = {1'b1, 3'd4, 5'b00100}; // F
            8'h34:      e = {1'b1, 3'd3, 5'b11000}; // G
            8'h33:      e = {1'b1, 3'd4, 5'b00000}; // H
            8'h43:      e = {1'b1, 3'd2, 5'b00000}; // I
            8'h3B:      e = {1'b1, 3'd4, 5'b01110}; // J
            8'h42:      e = {1'b1, 3'd3, 5'b10100}; // K
            8'h4B:      e = {1'b1, 3'd4, 5'b01000}; // L
            8'h3A:      e = {1'b1, 3'd2, 5'b11000}; // M
            8'h31:      e = {1'b1, 3'd2, 5'b10000}; // N
            8'h44:      e = {1'b1, 3'd3, 5'b11100}; // O
            8'h4D:      e = {1'b1, 3'd4, 5'b01100}; // P
            8'h15:      e = {1'b1, 3'd4, 5'b11010}; // Q
            8'h2D:      e = {1'b1, 3'd3, 5'b01000}; // R
            8'h1B:      e = {1'b1, 3'd3, 5'b00000}; // S
            8'h2C:      e = {1'b1, 3'd1, 5'b10000}; // T
            8'h3C:      e = {1'b1, 3'd3, 5'b00100}; // U
            8'h2A:      e = {1'b1, 3'd4, 5'b00010}; // V
            8'h1D:      e = {1'b1, 3'd3, 5'b01100}; // W
            8'h22:      e = {1'b1, 3'd4, 5'b10010}; // X
            8'h35:      e = {1'b1, 3'd4, 5'b10110}; // Y
            8'h1A:      e = {1'b1, 3'd4, 5'b11000}; // Z
            8'h45:      e = {1'b1, 3'd5, 5'b11111}; // 0
            8'h16:      e = {1'b1, 3'd5, 5'b01111}; // 1
            8'h1E:      e = {1'b1, 3'd5, 5'b00111}; // 2
            8'h26:      e = {1'b1, 3'd5, 5'b00011}; // 3
            8'h25:      e = {1'b1, 3'd5, 5'b00001}; // 4
            8'h2E:      e = {1'b1, 3'd5, 5'b00000}; // 5
            8'h36:      e = {1'b1, 3'd5, 5'b10000}; // 6
            8'h3D:      e = {1'b1, 3'd5, 5'b11000}; // 7
            8'h3E:      e = {1'b1, 3'd5, 5'b11100}; // 8
            8'h46:      e = {1'b1, 3'd5, 5'b11110}; // 9
            SPACE_CODE: e = {1'b1, 3'd0, 5'b00000};
            default:    e = {1'b0, 3'd0, 5'b00000};
        endcase
        return e;
    endfunction

    // Data bits plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes the lines, samples on falling
// clock edges, checks start/parity/stop and drops partial frames after a timeout.
module ps2_rx
    import ps2_morse_pkg::*;
#(
    parameter int TIMEOUT = 20_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          clk_prev_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic [TW-1:0] idle_cnt_r;
    logic [7:0]    code_r;
    logic          code_valid_r;
    logic          frame_err_r;
    logic          fall_s;
    logic          frame_ok_s;

    assign fall_s = clk_prev_r & ~clk_sync_r[1];

    // Frame check at the stop bit: shift_r holds {parity, data[7:0], start}
    always_comb begin
        frame_ok_s = (shift_r[0] == 1'b0) && data_sync_r[1] && odd_parity_ok(shift_r[9:1]);
    end

    // Line synchronizers; idle-high reset avoids a false edge after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
            clk_prev_r  <= clk_sync_r[1];
        end
    end

    // Bit assembly, frame validation and idle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            idle_cnt_r   <= '0;
            code_r       <= 8'd0;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            if (fall_s) begin
                idle_cnt_r <= '0;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (frame_ok_s) begin
                        code_r       <= shift_r[8:1];
                        code_valid_r <= 1'b1;
                        frame_err_r  <= 1'b0;
                    end else begin
                        frame_err_r  <= 1'b1;
                    end
                end else begin
                    shift_r   <= {data_sync_r[1], shift_r[9:1]};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (idle_cnt_r == IDLE_LAST) begin
                bit_cnt_r <= 4'd0;
            end else begin
                idle_cnt_r <= idle_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign code       = code_r;
    assign code_valid = code_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_morse_decoder_top.sv
// Tiny Tapeout top: PS/2 scan codes in, Morse code out as a keyed level and a gated tone.
module ps2_morse_decoder_top
    import ps2_morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1_000_000,
    parameter int TONE_HALF   = 5_000,
    parameter int PS2_TIMEOUT = 20_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int            CW        = $clog2(UNIT_CYCLES + 1);
    localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);
    localparam int            HW        = $clog2(TONE_HALF + 1);
    localparam logic [HW-1:0] TONE_LAST = HW'(TONE_HALF - 1);

    logic [7:0]    rx_code_s;
    logic          rx_valid_s;
    logic          frame_err_s;
    logic          unused_s;

    logic          break_r;
    logic          ext_r;
    logic          make_s;
    morse_entry_t  entry_s;

    seq_state_e    state_r, state_next;
    logic [4:0]    pat_r, pat_next;
    logic [2:0]    left_r, left_next;
    logic          space_r, space_next;
    logic [CW-1:0] cyc_r, cyc_next;
    logic [2:0]    unit_r, unit_next;
    logic [2:0]    target_s;

    logic [HW-1:0] tone_cnt_r;
    logic          tone_phase_r;
    logic          key_r;
    logic          tone_r;
    logic          busy_r;

    assign unused_s = &{1'b0, ena, uio_in, ui_in[7:2]};

    ps2_rx #(
        .TIMEOUT (PS2_TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ui_in[0]),
        .ps2_data   (ui_in[1]),
        .code       (rx_code_s),
        .code_valid (rx_valid_s),
        .frame_err  (frame_err_s)
    );

    // Make-code qualification: prefixes arm flags, the code after a prefix is swallowed
    always_comb begin
        make_s  = rx_valid_s && (rx_code_s != BREAK_CODE) && (rx_code_s != EXT_CODE)
                  && !break_r && !ext_r;
        entry_s = morse_lookup(rx_code_s);
    end

    // Break/extended prefix flags
    always_ff @(posedge clk) begin
        if (rst) begin
            break_r <= 1'b0;
            ext_r   <= 1'b0;
        end else if (rx_valid_s) begin
            if (rx_code_s == BREAK_CODE) begin
                break_r <= 1'b1;
            end else if (rx_code_s == EXT_CODE) begin
                ext_r <= 1'b1;
            end else begin
                break_r <= 1'b0;
                ext_r   <= 1'b0;
            end
        end
    end

    // Units spent in the current state
    always_comb begin
        case (state_r)
            MARK:    target_s = pat_r[4] ? 3'd3 : 3'd1;
            GAP:     target_s = 3'd1;
            LGAP:    target_s = space_r ? 3'd7 : 3'd3;
            default: target_s = 3'd1;
        endcase
    end

    // Sequencer next-state: element pattern shifts left after every mark
    always_comb begin
        state_next = state_r;
        pat_next   = pat_r;
        left_next  = left_r;
        space_next = space_r;
        cyc_next   = cyc_r;
        unit_next  = unit_r;
        case (state_r)
            IDLE: begin
                if (make_s && entry_s.valid) begin
                    cyc_next  = '0;
                    unit_next = 3'd0;
                    if (entry_s.len == 3'd0) begin
                        state_next = LGAP;
                        space_next = 1'b1;
                    end else begin
                        state_next = MARK;
                        space_next = 1'b0;
                        pat_next   = entry_s.pat;
                        left_next  = entry_s.len;
                    end
                end else begin
                    cyc_next  = '0;
                    unit_next = 3'd0;
                end
            end
            default: begin
                if (cyc_r == UNIT_LAST) begin
                    cyc_next = '0;
                    if (unit_r == target_s - 3'd1) begin
                        unit_next = 3'd0;
                        case (state_r)
                            MARK: begin
                                pat_next   = {pat_r[3:0], 1'b0};
                                left_next  = left_r - 3'd1;
                                state_next = (left_r == 3'd1) ? LGAP : GAP;
                            end
                            GAP:     state_next = MARK;
                            LGAP:    state_next = IDLE;
                            default: state_next = IDLE;
                        endcase
                    end else begin
                        unit_next = unit_r + 3'd1;
                    end
                end else begin
                    cyc_next = cyc_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        endcase
    end

    // Sequencer state and output registers; outputs track the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pat_r   <= 5'd0;
            left_r  <= 3'd0;
            space_r <= 1'b0;
            cyc_r   <= '0;
            unit_r  <= 3'd0;
            key_r   <= 1'b0;
            tone_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            pat_r   <= pat_next;
            left_r  <= left_next;
            space_r <= space_next;
            cyc_r   <= cyc_next;
            unit_r  <= unit_next;
            key_r   <= (state_next == MARK);
            tone_r  <= tone_phase_r & (state_next == MARK);
            busy_r  <= (state_next != IDLE);
        end
    end

    // Free-running tone square wave
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_r   <= '0;
            tone_phase_r <= 1'b0;
        end else if (tone_cnt_r == TONE_LAST) begin
            tone_cnt_r   <= '0;
            tone_phase_r <= ~tone_phase_r;
        end else begin
            tone_cnt_r   <= tone_cnt_r + {{(HW-1){1'b0}}, 1'b1};
        end
    end

    assign uo_out  = {4'b0000, frame_err_s, busy_r, tone_r, key_r};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_ps2_morse_decoder_top.sv
// Directed bench: sends PS/2 frames and checks the Morse key/busy/tone timing.
module tb_ps2_morse_decoder_top;

    localparam int UNIT  = 20;
    localparam int THALF = 2;
    localparam int TOUT  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {6'b000000, ps2_data, ps2_clk};

    ps2_morse_decoder_top #(
        .UNIT_CYCLES (UNIT),
        .TONE_HALF   (THALF),
        .PS2_TIMEOUT (TOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    run_val[$];
    int    run_len[$];
    string runs_s;
    int    tone_changes;
    int    tone_bad;
    int    busy_cycles;
    bit    started;

    // Send nbits of an 11-bit frame; half = PS/2 clock half-period in clk cycles
    task automatic send_frame(input logic [7:0] code, input bit bad_parity,
                              input int half, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat ((i == 10) ? 2 : half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Record key run lengths while busy is high
    task automatic capture(input int start_limit, input int max_len);
        int   n;
        logic prev_key;
        logic prev_tone;
        run_val.delete();
        run_len.delete();
        runs_s = "";
        tone_changes = 0;
        tone_bad = 0;
        busy_cycles = 0;
        started = 1'b0;
        n = 0;
        while (!uo_out[2] && n < start_limit) begin
            @(negedge clk);
            n++;
        end
        if (uo_out[2]) begin
            started = 1'b1;
            prev_key = 1'b0;
            prev_tone = 1'b0;
            n = 0;
            while (uo_out[2] && n < max_len) begin
                if (run_val.size() == 0 || run_val[run_val.size()-1] != int'(uo_out[0])) begin
                    run_val.push_back(int'(uo_out[0]));
                    run_len.push_back(1);
                end else begin
                    run_len[run_len.size()-1]++;
                end
                if (!uo_out[0] && uo_out[1]) tone_bad++;
                if (uo_out[0] && prev_key && (uo_out[1] !== prev_tone)) tone_changes++;
                prev_key = uo_out[0];
                prev_tone = uo_out[1];
                busy_cycles++;
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < run_val.size(); i++) begin
                if (i > 0) runs_s = {runs_s, " "};
                runs_s = {runs_s, $sformatf("%0d:%0d", run_val[i], run_len[i])};
            end
            if (uo_out[2]) runs_s = {runs_s, " stuck"};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (uo_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        tests++;
        if ({uio_out, uio_oe} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_uio: got %h/%h expected 00/00", uio_out, uio_oe);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_letter_e();
        send_frame(8'h24, 1'b0, 20, 11);
        capture(20, 1000);
        tests++;
        if (runs_s != "1:20 0:60") begin
            fails++;
            $display("FAIL e_pattern: got '%s' expected '1:20 0:60'", runs_s);
        end
        tests++;
        if (busy_cycles !== 80) begin
            fails++;
            $display("FAIL e_busy_len: got %0d expected 80", busy_cycles);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_letter_a_tone();
        send_frame(8'h1C, 1'b0, 20, 11);
        capture(20, 1000);
        tests++;
        if (runs_s != "1:20 0:20 1:60 0:60") begin
            fails++;
            $display("FAIL a_pattern: got '%s' expected '1:20 0:20 1:60 0:60'", runs_s);
        end
        tests++;
        if (tone_bad !== 0) begin
            fails++;
            $display("FAIL tone_gated: got %0d tone-high cycles with key low, expected 0", tone_bad);
        end
        tests++;
        if (tone_changes < 30) begin
            fails++;
            $display("FAIL tone_toggles: got %0d toggles while keyed, expected >= 30", tone_changes);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 20, 11);
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b0, 20, 11);
        capture(300, 1000);
        tests++;
        if (started !== 1'b0) begin
            fails++;
            $display("FAIL break_silent: got busy=%0d pattern '%s' expected no busy", started, runs_s);
        end
        tests++;
        if (uo_out !== 8'h00) begin
            fails++;
            $display("FAIL break_outputs: got %h expected 00", uo_out);
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'h24, 1'b1, 20, 11);
        capture(200, 1000);
        tests++;
        if (started !== 1'b0) begin
            fails++;
            $display("FAIL parity_silent: got busy=%0d expected 0", started);
        end
        tests++;
        if (uo_out[3] !== 1'b1) begin
            fails++;
            $display("FAIL parity_frame_err: got %b expected 1", uo_out[3]);
        end
        send_frame(8'h2C, 1'b0, 20, 11);
        capture(20, 1000);
        tests++;
        if (uo_out[3] !== 1'b0) begin
            fails++;
            $display("FAIL frame_err_clear: got %b expected 0", uo_out[3]);
        end
        tests++;
        if (runs_s != "1:60 0:60") begin
            fails++;
            $display("FAIL t_pattern: got '%s' expected '1:60 0:60'", runs_s);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_timeout();
        send_frame(8'h24, 1'b0, 20, 5);
        repeat (300) @(negedge clk);
        send_frame(8'h24, 1'b0, 20, 11);
        capture(20, 1000);
        tests++;
        if (runs_s != "1:20 0:60") begin
            fails++;
            $display("FAIL timeout_pattern: got '%s' expected '1:20 0:60'", runs_s);
        end
        tests++;
        if (uo_out[3] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_frame_err: got %b expected 0", uo_out[3]);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_busy_drop();
        int rises;
        send_frame(8'h1C, 1'b0, 20, 11);
        fork
            capture(20, 1000);
            begin
                repeat (10) @(negedge clk);
                send_frame(8'h24, 1'b0, 5, 11);
            end
        join
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            if (uo_out[2]) rises++;
            @(negedge clk);
        end
        tests++;
        if (runs_s != "1:20 0:20 1:60 0:60") begin
            fails++;
            $display("FAIL drop_pattern: got '%s' expected '1:20 0:20 1:60 0:60'", runs_s);
        end
        tests++;
        if (rises !== 0) begin
            fails++;
            $display("FAIL drop_busy_once: got %0d busy cycles after playback expected 0", rises);
        end
    endtask

    task automatic test_reset_mid_dash();
        int n;
        send_frame(8'h2C, 1'b0, 20, 11);
        n = 0;
        while (!uo_out[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (uo_out[0] !== 1'b1) begin
            fails++;
            $display("FAIL dash_start: got key=%b expected 1", uo_out[0]);
        end
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (uo_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_dash: got %h expected 00", uo_out);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h24, 1'b0, 20, 11);
        capture(20, 1000);
        tests++;
        if (runs_s != "1:20 0:60") begin
            fails++;
            $display("FAIL post_reset_e: got '%s' expected '1:20 0:60'", runs_s);
        end
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_a_tone();
        test_break();
        test_parity_error();
        test_timeout();
        test_busy_drop();
        test_reset_mid_dash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded 200000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
